ysyx_22041207_mem_bridge: RTL and testbench
===========================================

YSYX_22041207_MEM_BRIDGE -- requirements
Module: ysyx_22041207_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: backend wait limit in cycles; used only with YSYX_22041207_BRIDGE_TIMEOUT_EN.
REQ-002 SHALL have ports (clock and reset first):
  clk  in  1  clock; all state updates on posedge.
  rst  in  1  reset; synchronous, active-high.
  w_valid_i  in  1  write request valid.
  w_ready_o  out  1  write request accepted.
  w_addr_i  in  64  write byte address.
  w_data_i  in  64  write data, already lane-aligned by the requester.
  w_mask_i  in  8  byte strobes, already lane-aligned.
  w_valid_o  out  1  write done.
  w_ready_i  in  1  requester takes the write-done response.
  r_valid_i  in  1  read request valid.
  r_ready_o  out  1  read request accepted.
  r_addr_i  in  64  read byte address.
  r_size_i  in  8  read size in bytes: 1, 2, 4 or 8.
  data_read_o  out  64  read data, right-aligned.
  data_valid  out  1  read data valid.
  data_ready  in  1  requester takes the read data.
  mem_req  out  1  backend request.
  mem_we  out  1  backend write enable.
  mem_addr  out  64  doubleword-aligned backend address.
  mem_wdata  out  64  backend write data.
  mem_wmask  out  8  backend byte strobes.
  mem_ack  in  1  backend completion; read data valid in the same cycle.
  mem_rdata  in  64  backend read doubleword.
  err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, W_MEM, W_RESP, R_MEM, R_RESP.
REQ-004 SHALL assert w_ready_o and r_ready_o only in IDLE; both SHALL be 0 in all other states.
REQ-005 In IDLE with w_valid_i=1, SHALL latch addr, data and mask, then go to W_MEM. Write SHALL take priority when w_valid_i and r_valid_i are both 1; the read SHALL stay pending, not accepted.
REQ-006 In IDLE with only r_valid_i=1, SHALL latch addr and size, then go to R_MEM.
REQ-007 In W_MEM/R_MEM, SHALL hold mem_req=1 and stable outputs until the cycle mem_ack=1:
  mem_addr={addr[63:3],3'b000}.
  mem_we=1 for writes.
  mem_wdata/mem_wmask passed unmodified.
  All mem_* outputs SHALL be 0 outside W_MEM/R_MEM.
REQ-008 On mem_ack in W_MEM, SHALL go to W_RESP; w_valid_o=1 held until w_ready_i=1, then IDLE.
REQ-009 On mem_ack in R_MEM, SHALL register data_read_o = (mem_rdata >> 8*addr[2:0]), zero-masked to r_size_i bytes, then go to R_RESP.
  Sizes other than 1/2/4/8 SHALL pass all 64 bits.
  Bytes shifted past bit 63 SHALL read as 0; no second access is made.
REQ-010 In R_RESP, data_valid=1 and data_read_o SHALL be held stable until data_ready=1, then IDLE.
REQ-011 Latency: accept-to-response SHALL be 2 cycles minimum, when mem_ack=1 in the first mem_req cycle.
REQ-012 mem_ack outside W_MEM/R_MEM SHALL be ignored.
REQ-013 Only one transaction SHALL be outstanding; a new request SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-014 rst=1 SHALL force IDLE on the next posedge, aborting any transaction.
REQ-015 On reset, SHALL clear to 0: w_valid_o, data_valid, data_read_o, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err and the timeout counter.
REQ-016 w_ready_o=r_ready_o=1 SHALL hold in the first cycle after reset release.

Configuration
REQ-017 With YSYX_22041207_BRIDGE_TIMEOUT_EN defined:
  A counter SHALL count mem_req cycles without mem_ack.
  At TIMEOUT_CYCLES, the bridge SHALL drop mem_req and enter W_RESP/R_RESP with data_read_o=0.
  err SHALL be set and stay set until reset.
  The counter SHALL clear on each new accept.
REQ-018 Without the macro, the bridge SHALL wait indefinitely for mem_ack, err SHALL be tied 0, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-019 Write: addr=0x80000004, data=0x11223344_00000000, mask=0xF0, mem_ack 3 cycles later -> one mem_req pulse train with mem_addr=0x80000000, mem_wmask=0xF0; w_valid_o held until w_ready_i.
REQ-020 Read: addr=0x80000006, size=2, mem_rdata=0xAABB_0000_0000_0000 -> data_read_o=0x000000000000AABB, data_valid held 4 cycles while data_ready=0.
REQ-021 Simultaneous w_valid_i and r_valid_i in IDLE -> write accepted first; read accepted in the first IDLE cycle after w_valid_o/w_ready_i handshake.
REQ-022 rst=1 during R_MEM with mem_ack pending -> next cycle IDLE, mem_req=0, data_valid=0; a later mem_ack causes no response.
REQ-023 Macro defined, TIMEOUT_CYCLES=8, mem_ack never asserted -> mem_req high exactly 8 cycles, then data_valid=1, data_read_o=0, err=1 until reset.
REQ-024 Read: size=8 at addr=0x80000003 -> data_read_o holds the upper 5 bytes of mem_rdata, upper 3 bytes zero.

Source files
------------

// File: rtl/ysyx_22041207_mem_bridge.sv
// Single-outstanding request bridge from split write/read ports to a doubleword memory backend.
// Optional backend timeout guarded by YSYX_22041207_BRIDGE_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module ysyx_22041207_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    input  logic [63:0] w_addr_i,
    input  logic [63:0] w_data_i,
    input  logic [7:0]  w_mask_i,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [63:0] r_addr_i,
    input  logic [7:0]  r_size_i,
    output logic [63:0] data_read_o,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEM,
        W_RESP,
        R_MEM,
        R_RESP
    } state_t;

    state_t      state;
    logic [63:0] addr;
    logic [7:0]  size;

    // Shift the addressed byte down to bit 0; bytes beyond the doubleword read as zero.
    function automatic logic [63:0] align_read(
        input logic [63:0] raw,
        input logic [2:0]  off,
        input logic [7:0]  sz
    );
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (sz)
            8'd1:    align_read = {56'd0, sh[7:0]};
            8'd2:    align_read = {48'd0, sh[15:0]};
            8'd4:    align_read = {32'd0, sh[31:0]};
            default: align_read = sh;
        endcase
    endfunction

`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    assign w_ready_o = (state == IDLE);
    assign r_ready_o = (state == IDLE);
    assign mem_addr  = mem_req ? {addr[63:3], 3'b000} : 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            size        <= '0;
            w_valid_o   <= 1'b0;
            data_valid  <= 1'b0;
            data_read_o <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (w_valid_i) begin
                        addr      <= w_addr_i;
                        mem_wdata <= w_data_i;
                        mem_wmask <= w_mask_i;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        state     <= W_MEM;
`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end else if (r_valid_i) begin
                        addr    <= r_addr_i;
                        size    <= r_size_i;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= R_MEM;
`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                W_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        w_valid_o <= 1'b1;
                        state     <= W_RESP;
                    end
`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
                    else if (cnt == LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        w_valid_o <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= W_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                R_MEM: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        data_read_o <= align_read(mem_rdata, addr[2:0], size);
                        data_valid  <= 1'b1;
                        state       <= R_RESP;
                    end
`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
                    else if (cnt == LAST) begin
                        mem_req     <= 1'b0;
                        data_read_o <= '0;
                        data_valid  <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= R_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                W_RESP: begin
                    if (w_ready_i) begin
                        w_valid_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                R_RESP: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_mem_bridge.sv
// Bench for ysyx_22041207_mem_bridge: vector table with scoreboard plus corner sequences.
// The timeout sequence runs only when YSYX_22041207_BRIDGE_TIMEOUT_EN is defined.
module tb_ysyx_22041207_mem_bridge;

    logic        clk;
    logic        rst;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [63:0] w_addr_i;
    logic [63:0] w_data_i;
    logic [7:0]  w_mask_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic        r_valid_i;
    logic        r_ready_o;
    logic [63:0] r_addr_i;
    logic [7:0]  r_size_i;
    logic [63:0] data_read_o;
    logic        data_valid;
    logic        data_ready;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        err;

    ysyx_22041207_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o),
        .w_addr_i(w_addr_i),
        .w_data_i(w_data_i),
        .w_mask_i(w_mask_i),
        .w_valid_o(w_valid_o),
        .w_ready_i(w_ready_i),
        .r_valid_i(r_valid_i),
        .r_ready_o(r_ready_o),
        .r_addr_i(r_addr_i),
        .r_size_i(r_size_i),
        .data_read_o(data_read_o),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [7:0]  size;
        logic [63:0] rdata;
        int          ack_dly;
        int          resp_dly;
        logic [63:0] exp_maddr;
        logic [63:0] exp_out;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [63:0] data;
    } exp_t;

    vec_t        vecs[9];
    exp_t        sb[$];
    int          applied;
    int          miscompares;
    logic [63:0] seen_wdata;

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
        applied++;
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        check("idle_w_ready", w_ready_o, 1);
        check("idle_r_ready", r_ready_o, 1);
        if (v.wr) begin
            w_valid_i = 1; w_addr_i = v.addr; w_data_i = v.data; w_mask_i = v.mask;
        end else begin
            r_valid_i = 1; r_addr_i = v.addr; r_size_i = v.size;
        end
        sb.push_back('{v.wr, v.wr ? v.data : v.exp_out});
        for (int i = 0; i <= v.ack_dly; i++) begin
            @(negedge clk);
            w_valid_i = 0;
            r_valid_i = 0;
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, v.exp_maddr);
            check("mem_we", mem_we, v.wr);
            if (v.wr) check("mem_wmask", mem_wmask, v.mask);
            check("early_resp", w_valid_o | data_valid, 0);
            check("busy_ready", w_ready_o | r_ready_o, 0);
            if (i == v.ack_dly) begin
                mem_ack = 1;
                mem_rdata = v.rdata;
                seen_wdata = mem_wdata;
            end
        end
        for (int i = 0; i <= v.resp_dly; i++) begin
            @(negedge clk);
            mem_ack = 0;
            mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            check("mem_req_off", mem_req, 0);
            check("mem_addr_off", mem_addr, 0);
            if (sb.size() == 0) begin
                check("sb_empty", 0, 1);
            end else if (i < v.resp_dly) begin
                e = sb[0];
                if (e.wr) check("w_valid_o", w_valid_o, 1);
                else begin
                    check("data_valid", data_valid, 1);
                    check("data_read_o", data_read_o, e.data);
                end
            end else begin
                e = sb.pop_front();
                if (e.wr) begin
                    check("w_valid_o", w_valid_o, 1);
                    check("mem_wdata", seen_wdata, e.data);
                end else begin
                    check("data_valid", data_valid, 1);
                    check("data_read_o", data_read_o, e.data);
                end
            end
            if (i == v.resp_dly) begin
                w_ready_i = v.wr;
                data_ready = !v.wr;
            end
        end
        @(negedge clk);
        w_ready_i = 0;
        data_ready = 0;
        check("resp_drop", w_valid_o | data_valid, 0);
        check("back_idle", r_ready_o, 1);
    endtask

    initial begin
        applied = 0;
        miscompares = 0;
        seen_wdata = '0;
        rst = 1; w_valid_i = 0; w_addr_i = '0; w_data_i = '0; w_mask_i = '0;
        w_ready_i = 0; r_valid_i = 0; r_addr_i = '0; r_size_i = '0;
        data_ready = 0; mem_ack = 0; mem_rdata = '0;

        vecs[0] = '{1, 64'h8000_0004, 64'h1122_3344_0000_0000, 8'hF0, 8'd0, 64'h0, 3, 2,
                    64'h8000_0000, 64'h0};
        vecs[1] = '{0, 64'h8000_0006, 64'h0, 8'h0, 8'd2, 64'hAABB_0000_0000_0000, 1, 4,
                    64'h8000_0000, 64'h0000_0000_0000_AABB};
        vecs[2] = '{0, 64'h8000_0003, 64'h0, 8'h0, 8'd8, 64'h0102_0304_0506_0708, 0, 1,
                    64'h8000_0000, 64'h0000_0001_0203_0405};
        vecs[3] = '{0, 64'h1007, 64'h0, 8'h0, 8'd1, 64'h8877_6655_4433_2211, 0, 0,
                    64'h1000, 64'h88};
        vecs[4] = '{0, 64'h2004, 64'h0, 8'h0, 8'd4, 64'hDEAD_BEEF_CAFE_BABE, 2, 0,
                    64'h2000, 64'hDEAD_BEEF};
        vecs[5] = '{0, 64'h3000, 64'h0, 8'h0, 8'd3, 64'hFFEE_DDCC_BBAA_9988, 0, 0,
                    64'h3000, 64'hFFEE_DDCC_BBAA_9988};
        vecs[6] = '{0, 64'h4006, 64'h0, 8'h0, 8'd4, 64'h1234_5678_9ABC_DEF0, 1, 1,
                    64'h4000, 64'h1234};
        vecs[7] = '{1, 64'h10, 64'h0000_0000_5566_7788, 8'h0F, 8'd0, 64'h0, 0, 0,
                    64'h10, 64'h0};
        vecs[8] = '{0, 64'h8, 64'h0, 8'h0, 8'd1, 64'h0123_4567_89AB_CDA5, 0, 3,
                    64'h8, 64'hA5};

        repeat (2) @(negedge clk);
        check("rst_w_valid_o", w_valid_o, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data_read_o", data_read_o, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_err", err, 0);
        rst = 0;
        @(negedge clk);
        check("rel_w_ready", w_ready_o, 1);
        check("rel_r_ready", r_ready_o, 1);

        foreach (vecs[k]) run_vec(vecs[k]);

        // write and read raised together: write wins, read waits
        @(negedge clk);
        w_valid_i = 1; w_addr_i = 64'h100; w_data_i = 64'hCAFE; w_mask_i = 8'hFF;
        r_valid_i = 1; r_addr_i = 64'h208; r_size_i = 8'd8;
        @(negedge clk);
        w_valid_i = 0;
        check("prio_we", mem_we, 1);
        check("prio_addr", mem_addr, 64'h100);
        check("prio_r_ready", r_ready_o, 0);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        check("prio_w_valid", w_valid_o, 1);
        check("prio_no_read", mem_req, 0);
        w_ready_i = 1;
        @(negedge clk);
        w_ready_i = 0;
        check("prio_idle_r_ready", r_ready_o, 1);
        check("prio_not_yet", mem_req, 0);
        @(negedge clk);
        r_valid_i = 0;
        check("prio_rd_req", mem_req, 1);
        check("prio_rd_we", mem_we, 0);
        check("prio_rd_addr", mem_addr, 64'h208);
        mem_ack = 1;
        mem_rdata = 64'h0F0E_0D0C_0B0A_0908;
        @(negedge clk);
        mem_ack = 0;
        check("prio_rd_valid", data_valid, 1);
        check("prio_rd_data", data_read_o, 64'h0F0E_0D0C_0B0A_0908);
        data_ready = 1;
        @(negedge clk);
        data_ready = 0;
        check("prio_done", data_valid, 0);

        // reset while a read waits on the backend
        r_valid_i = 1; r_addr_i = 64'h500; r_size_i = 8'd8;
        @(negedge clk);
        r_valid_i = 0;
        check("abort_req", mem_req, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_mem_req", mem_req, 0);
        check("abort_data_valid", data_valid, 0);
        check("abort_idle", r_ready_o, 1);
        mem_ack = 1;
        mem_rdata = 64'h7777_7777_7777_7777;
        @(negedge clk);
        mem_ack = 0;
        check("stray_data_valid", data_valid, 0);
        check("stray_w_valid", w_valid_o, 0);
        check("stray_mem_req", mem_req, 0);
        check("stray_data", data_read_o, 0);

`ifdef YSYX_22041207_BRIDGE_TIMEOUT_EN
        begin
            int hi;
            hi = 0;
            @(negedge clk);
            r_valid_i = 1; r_addr_i = 64'h600; r_size_i = 8'd8;
            @(negedge clk);
            r_valid_i = 0;
            for (int i = 0; i < 20; i++) begin
                if (!mem_req) break;
                hi++;
                @(negedge clk);
            end
            check("to_req_cycles", 64'(hi), 8);
            check("to_data_valid", data_valid, 1);
            check("to_data", data_read_o, 0);
            check("to_err", err, 1);
            data_ready = 1;
            @(negedge clk);
            data_ready = 0;
            check("to_err_sticky", err, 1);
            rst = 1;
            @(negedge clk);
            rst = 0;
            check("to_err_clr", err, 0);
        end
`else
        check("err_tied", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
